// File: rtl/wb_arbiter_pkg.sv
// Shared CPU constants for the write-back arbiter.
// Holds default widths and requester index constants.
package wb_arbiter_pkg;

    // Default data and register-address widths (8 registers).
    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 3;

    // Requester indices; also the encoding of LAST_GRANT.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    // Winner index from a one-hot {grant1, grant0} pair.
    function automatic logic winner(input logic g1);
        return g1 ? REQ_LOAD : REQ_ALU;
    endfunction

endpackage

// File: rtl/wb_arbiter_mux_n.sv
// Parameterized 2:1 selector used for both data and address paths.
// Ports: a (sel=0), b (sel=1), sel, y.
module mux_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Ports: two valid/ready requesters in, one held write + RF_READY out.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              WRITEENABLE,
    output logic [ADDR_W-1:0] WRITEREG,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic              RF_READY,
    output logic              LAST_GRANT
);

    logic              space;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Output register is free now or drains this cycle.
    assign space = !WRITEENABLE || RF_READY;

    // Under contention the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case ({REQ1_VALID, REQ0_VALID})
            2'b01: grant0 = 1'b1;
            2'b10: grant1 = 1'b1;
            2'b11: begin
                if (LAST_GRANT == REQ_LOAD) grant0 = 1'b1;
                else                        grant1 = 1'b1;
            end
            default: ;
        endcase
    end

    assign REQ0_READY = space && grant0;
    assign REQ1_READY = space && grant1;

    // A grant implies the matching valid, so any ready is a transfer.
    assign xfer = REQ0_READY || REQ1_READY;

    mux_n #(.W(DATA_W)) u_data_mux (
        .a   (REQ0_DATA),
        .b   (REQ1_DATA),
        .sel (grant1),
        .y   (sel_data)
    );

    mux_n #(.W(ADDR_W)) u_addr_mux (
        .a   (REQ0_ADDR),
        .b   (REQ1_ADDR),
        .sel (grant1),
        .y   (sel_addr)
    );

    // Reset discards any held write and restores the pointer so
    // that the ALU wins the first contended cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WRITEENABLE <= 1'b0;
            WRITEREG    <= '0;
            WRITEDATA   <= '0;
            LAST_GRANT  <= REQ_LOAD;
        end else if (xfer) begin
            WRITEENABLE <= 1'b1;
            WRITEREG    <= sel_addr;
            WRITEDATA   <= sel_data;
            LAST_GRANT  <= winner(grant1);
        end else if (RF_READY) begin
            WRITEENABLE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes expected
// retires, a negedge monitor pops and compares on each retire.
module tb_wb_arbiter;

    logic       CLK;
    logic       RESET_N;
    logic       REQ0_VALID;
    logic [2:0] REQ0_ADDR;
    logic [7:0] REQ0_DATA;
    logic       REQ0_READY;
    logic       REQ1_VALID;
    logic [2:0] REQ1_ADDR;
    logic [7:0] REQ1_DATA;
    logic       REQ1_READY;
    logic       WRITEENABLE;
    logic [2:0] WRITEREG;
    logic [7:0] WRITEDATA;
    logic       RF_READY;
    logic       LAST_GRANT;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];

    wb_arbiter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REQ0_VALID  (REQ0_VALID),
        .REQ0_ADDR   (REQ0_ADDR),
        .REQ0_DATA   (REQ0_DATA),
        .REQ0_READY  (REQ0_READY),
        .REQ1_VALID  (REQ1_VALID),
        .REQ1_ADDR   (REQ1_ADDR),
        .REQ1_DATA   (REQ1_DATA),
        .REQ1_READY  (REQ1_READY),
        .WRITEENABLE (WRITEENABLE),
        .WRITEREG    (WRITEREG),
        .WRITEDATA   (WRITEDATA),
        .RF_READY    (RF_READY),
        .LAST_GRANT  (LAST_GRANT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every retire must match the next expected write.
    always @(negedge CLK) begin
        if (RESET_N && WRITEENABLE && RF_READY) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", {WRITEREG, WRITEDATA}, 0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("retire_reg", int'(WRITEREG), int'(e[10:8]));
                chk("retire_data", int'(WRITEDATA), int'(e[7:0]));
            end
        end
    end

    initial begin
        RESET_N    = 1'b0;
        RF_READY   = 1'b1;
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 3'd2;
        REQ0_DATA  = 8'h11;
        REQ1_VALID = 1'b1;
        REQ1_ADDR  = 3'd5;
        REQ1_DATA  = 8'hA0;
        repeat (3) tick();
        chk("rst_we", int'(WRITEENABLE), 0);
        chk("rst_reg", int'(WRITEREG), 0);
        chk("rst_data", int'(WRITEDATA), 0);
        chk("rst_last", int'(LAST_GRANT), 1);
        RESET_N = 1'b1;

        // Contention after reset: ALU first, then load.
        #1;
        chk("t1_rdy0", int'(REQ0_READY), 1);
        chk("t1_rdy1", int'(REQ1_READY), 0);
        push(3'd2, 8'h11);
        tick();
        chk("t1_we_a", int'(WRITEENABLE), 1);
        chk("t1_data_a", int'(WRITEDATA), 8'h11);
        REQ0_VALID = 1'b0;
        #1;
        chk("t1_rdy1b", int'(REQ1_READY), 1);
        push(3'd5, 8'hA0);
        tick();
        chk("t1_we_b", int'(WRITEENABLE), 1);
        chk("t1_data_b", int'(WRITEDATA), 8'hA0);

        // Single requester stream, no bubbles.
        REQ1_ADDR = 3'd6;
        for (int i = 1; i <= 4; i++) begin
            REQ1_DATA = 8'(i);
            #1;
            chk("t2_rdy0", int'(REQ0_READY), 0);
            chk("t2_rdy1", int'(REQ1_READY), 1);
            push(3'd6, 8'(i));
            tick();
            chk("t2_we", int'(WRITEENABLE), 1);
            chk("t2_data", int'(WRITEDATA), i);
        end
        REQ1_VALID = 1'b0;
        tick();
        chk("t2_drain_we", int'(WRITEENABLE), 0);

        // Backpressure with a held 0x33.
        RF_READY   = 1'b0;
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 3'd1;
        REQ0_DATA  = 8'h33;
        push(3'd1, 8'h33);
        tick();
        REQ0_ADDR  = 3'd3;
        REQ0_DATA  = 8'h44;
        REQ1_VALID = 1'b1;
        REQ1_ADDR  = 3'd7;
        REQ1_DATA  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_rdy0", int'(REQ0_READY), 0);
            chk("t3_rdy1", int'(REQ1_READY), 0);
            chk("t3_hold", int'(WRITEDATA), 8'h33);
            chk("t3_we", int'(WRITEENABLE), 1);
            tick();
        end
        RF_READY = 1'b1;
        #1;
        chk("t3_rel_rdy1", int'(REQ1_READY), 1);
        chk("t3_rel_rdy0", int'(REQ0_READY), 0);
        push(3'd7, 8'h55);
        tick();
        chk("t3_reload_we", int'(WRITEENABLE), 1);
        chk("t3_reload", int'(WRITEDATA), 8'h55);
        REQ1_VALID = 1'b0;
        push(3'd3, 8'h44);
        tick();
        REQ0_VALID = 1'b0;

        // Same destination register: order follows grants.
        REQ1_VALID = 1'b1;
        REQ1_ADDR  = 3'd0;
        REQ1_DATA  = 8'h5A;
        push(3'd0, 8'h5A);
        tick();
        chk("t4_last_pre", int'(LAST_GRANT), 1);
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 3'd4;
        REQ0_DATA  = 8'h10;
        REQ1_ADDR  = 3'd4;
        REQ1_DATA  = 8'h20;
        #1;
        chk("t4_rdy0", int'(REQ0_READY), 1);
        chk("t4_rdy1", int'(REQ1_READY), 0);
        push(3'd4, 8'h10);
        tick();
        chk("t4_last0", int'(LAST_GRANT), 0);
        REQ0_VALID = 1'b0;
        push(3'd4, 8'h20);
        tick();
        chk("t4_last1", int'(LAST_GRANT), 1);
        REQ1_VALID = 1'b0;

        // Reset mid-operation discards the held write.
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 3'd2;
        REQ0_DATA  = 8'h77;
        tick();
        REQ0_VALID = 1'b0;
        RF_READY   = 1'b0;
        chk("t5_we_pre", int'(WRITEENABLE), 1);
        chk("t5_last_pre", int'(LAST_GRANT), 0);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("t5_we_async", int'(WRITEENABLE), 0);
        chk("t5_data_rst", int'(WRITEDATA), 0);
        chk("t5_last_rst", int'(LAST_GRANT), 1);
        tick();
        RESET_N    = 1'b1;
        RF_READY   = 1'b1;
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 3'd1;
        REQ0_DATA  = 8'h88;
        REQ1_VALID = 1'b1;
        REQ1_ADDR  = 3'd2;
        REQ1_DATA  = 8'h99;
        #1;
        chk("t5_rdy0", int'(REQ0_READY), 1);
        chk("t5_rdy1", int'(REQ1_READY), 0);
        push(3'd1, 8'h88);
        tick();
        REQ0_VALID = 1'b0;
        push(3'd2, 8'h99);
        tick();
        REQ1_VALID = 1'b0;

        // Idle: last retire drains, no spurious readies.
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t6_we", int'(WRITEENABLE), 0);
            chk("t6_rdy0", int'(REQ0_READY), 0);
            chk("t6_rdy1", int'(REQ1_READY), 0);
            tick();
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
